// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide transmit buffer between CPU stores and the UART transmitter.
// Unpacks enabled store lanes (lane 3 first) into a circular FIFO and offers the head
// byte to the transmitter through the tx_start/tx_avai handshake.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    byteen,
    input  logic          flush,
    input  logic          clr_ovf,
    input  logic          tx_avai,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          overflow
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;

    logic [7:0]    packed_b [4];
    logic [2:0]    push_n;
    logic [AW:0]   room;
    logic          fits;
    logic          push;
    logic          reject;
    logic          pop;

    // Compact the enabled lanes, most significant first, into consecutive byte slots.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        packed_b = '{default: 8'h00};
        push_n   = 3'd0;
        for (int lane = 3; lane >= 0; lane--) begin
            if (byteen[lane]) begin
                packed_b[push_n[1:0]] = wr_data[lane*8 +: 8];
                push_n                = push_n + 3'd1;
            end
        end
    end

    // Admission uses the pre-pop level; flush swallows stores without flagging them.
    assign room   = DEPTH_W - level_q;
    assign fits   = (AW+1)'(push_n) <= room;
    assign push   = wr_en && !flush && fits && (push_n != 3'd0);
    assign reject = wr_en && !flush && !fits;

    assign empty    = (level_q == '0);
    assign full     = (level_q == DEPTH_W);
    assign level    = level_q;
    assign overflow = ovf_q;
    assign tx_start = !empty && !flush;
    assign pop      = tx_start && tx_avai;
    assign tx_data  = empty ? 8'h00 : mem_q[rd_ptr_q];

    // Next-state for pointers, level and the sticky overflow flag; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(push_n);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            level_d = level_q + (push ? (AW+1)'(push_n) : '0) - (pop ? (AW+1)'(1) : '0);
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (reject) begin
            ovf_d = 1'b1;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Byte storage: write up to four packed bytes at consecutive slots, wrapping modulo DEPTH.
    // NOTE: the data array has no reset; level gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < push_n) begin
                    mem_q[wr_ptr_q + AW'(i)] <= packed_b[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo (DEPTH = 16).
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [3:0]  byteen;
    logic        flush;
    logic        clr_ovf;
    logic        tx_avai;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [4:0]  level;
    logic        empty;
    logic        full;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    // Transmitter model: captures on tx_start & tx_avai, then stays busy two cycles.
    logic       model_on;
    logic       avai_manual;
    logic       avai_model;
    int         busy_cnt;
    int         pop_count;
    logic [7:0] rx_q [$];

    assign tx_avai = model_on ? avai_model : avai_manual;

    uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .byteen   (byteen),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .tx_avai  (tx_avai),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && tx_start && tx_avai) begin
            rx_q.push_back(tx_data);
            pop_count = pop_count + 1;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            avai_model <= 1'b1;
            busy_cnt   <= 0;
        end else if (model_on && avai_model && tx_start) begin
            avai_model <= 1'b0;
            busy_cnt   <= 0;
        end else if (!avai_model) begin
            if (busy_cnt == 1) avai_model <= 1'b1;
            busy_cnt <= busy_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the store takes effect at the following posedge.
    task automatic store(input logic [31:0] d, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_data = d;
        byteen  = be;
        @(negedge clk);
        wr_en   = 1'b0;
        byteen  = 4'b0000;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
    endtask

    task automatic drain(input string tag);
        model_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (empty) break;
            @(negedge clk);
        end
        check({tag, "_drained"}, {31'd0, empty}, 32'd1);
        model_on = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] exp_seq [15];
    int         pops_before;

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; byteen = '0;
        flush = 1'b0; clr_ovf = 1'b0; avai_manual = 1'b0; model_on = 1'b0;
        pop_count = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Word store, drained by the transmitter model.
        store(32'h4142_4344, 4'b1111);
        check("word_level", 32'(level), 32'd4);
        check("word_tx_start", 32'(tx_start), 32'd1);
        check("word_head", 32'(tx_data), 32'h41);
        rx_q.delete();
        pops_before = pop_count;
        drain("word");
        check("word_pops", 32'(pop_count - pops_before), 32'd4);
        check("word_rx_count", 32'(rx_q.size()), 32'd4);
        if (rx_q.size() == 4) begin
            check("word_b0", 32'(rx_q[0]), 32'h41);
            check("word_b1", 32'(rx_q[1]), 32'h42);
            check("word_b2", 32'(rx_q[2]), 32'h43);
            check("word_b3", 32'(rx_q[3]), 32'h44);
        end
        check("word_empty", 32'(empty), 32'd1);

        // Sparse lanes 2 and 0.
        rx_q.delete();
        store(32'h0055_0066, 4'b0101);
        check("sparse_level", 32'(level), 32'd2);
        drain("sparse");
        check("sparse_rx_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            check("sparse_b0", 32'(rx_q[0]), 32'h55);
            check("sparse_b1", 32'(rx_q[1]), 32'h66);
        end

        // Zero byte enables are a no-op.
        store(32'hDEAD_BEEF, 4'b0000);
        check("noop_level", 32'(level), 32'd0);
        check("noop_ovf", 32'(overflow), 32'd0);

        // Overflow with the transmitter held off.
        pulse_flush();
        store(32'h0102_0304, 4'b1111);
        store(32'h0506_0708, 4'b1111);
        store(32'h090A_0B0C, 4'b1111);
        store(32'h0D0E_0F10, 4'b1111);
        check("ovf_level16", 32'(level), 32'd16);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_not_yet", 32'(overflow), 32'd0);
        store(32'h0000_00EE, 4'b0001);
        check("ovf_level_kept", 32'(level), 32'd16);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head", 32'(tx_data), 32'h01);
        pulse_clr();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Boundary store with concurrent pop; bytes equal to slot indices.
        pulse_flush();
        store(32'h0001_0203, 4'b1111);
        store(32'h0405_0607, 4'b1111);
        store(32'h0809_0A0B, 4'b1111);
        store(32'h0000_0C0D, 4'b0011);
        check("bnd_level14", 32'(level), 32'd14);
        avai_manual = 1'b1;
        @(negedge clk);
        avai_manual = 1'b0;
        check("bnd_level13", 32'(level), 32'd13);
        check("bnd_head01", 32'(tx_data), 32'h01);
        avai_manual = 1'b1;
        store(32'hA1A2_A3A4, 4'b1111);
        check("bnd_reject_level", 32'(level), 32'd12);
        check("bnd_reject_ovf", 32'(overflow), 32'd1);
        check("bnd_head02", 32'(tx_data), 32'h02);
        store(32'hB1B2_B3B4, 4'b1111);
        avai_manual = 1'b0;
        check("bnd_accept_level", 32'(level), 32'd15);
        check("bnd_head03", 32'(tx_data), 32'h03);
        for (int i = 0; i < 11; i++) exp_seq[i] = 8'(i + 3);
        exp_seq[11] = 8'hB1; exp_seq[12] = 8'hB2; exp_seq[13] = 8'hB3; exp_seq[14] = 8'hB4;
        rx_q.delete();
        drain("bnd");
        check("bnd_rx_count", 32'(rx_q.size()), 32'd15);
        if (rx_q.size() == 15) begin
            for (int i = 0; i < 15; i++) check($sformatf("bnd_b%0d", i), 32'(rx_q[i]), 32'(exp_seq[i]));
        end

        // Flush with concurrent pop request and store; overflow is still set from above.
        store(32'h1122_3344, 4'b1111);
        store(32'h0000_5566, 4'b0011);
        check("fl_level6", 32'(level), 32'd6);
        pops_before = pop_count;
        flush = 1'b1; avai_manual = 1'b1;
        wr_en = 1'b1; wr_data = 32'h0000_0077; byteen = 4'b0001;
        #1;
        check("fl_tx_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        flush = 1'b0; avai_manual = 1'b0; wr_en = 1'b0; byteen = 4'b0000;
        check("fl_level", 32'(level), 32'd0);
        check("fl_empty", 32'(empty), 32'd1);
        check("fl_no_pop", 32'(pop_count - pops_before), 32'd0);
        check("fl_ovf_kept", 32'(overflow), 32'd1);
        store(32'h0000_00C3, 4'b0001);
        check("fl_after_head", 32'(tx_data), 32'hC3);
        check("fl_after_level", 32'(level), 32'd1);

        // Set wins over a simultaneous clear: fill, then reject while clearing.
        store(32'hC4C5_C6C7, 4'b1111);
        store(32'hC8C9_CACB, 4'b1111);
        store(32'hCCCD_CECF, 4'b1111);
        store(32'hD0D1_D2D3, 4'b0111);
        check("set_win_full", 32'(full), 32'd1);
        clr_ovf = 1'b1;
        store(32'h0000_00FF, 4'b0001);
        clr_ovf = 1'b0;
        check("set_win_ovf", 32'(overflow), 32'd1);

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_tx_start", 32'(tx_start), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_full", 32'(full), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_tx_data", 32'(tx_data), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-wide transmit buffer between the CPU store path and the UART transmitter. It accepts 32-bit bus stores with byte enables and unpacks the enabled bytes, most significant lane first, into a circular FIFO. It then drains the FIFO one byte at a time into the transmitter through the `tx_start`/`tx_avai` handshake. Software can queue up to DEPTH bytes without polling the transmitter between bytes.

## Interface
- `DEPTH`, default 16: FIFO capacity in bytes. Power of two, minimum 4.
- `AW`, default 4: pointer width, equal to log2(DEPTH).
- `clk`, input, 1: the single clock; all state is updated on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `wr_en`, input, 1: a bus store to the UART data register is valid this cycle.
- `wr_data`, input, 32: store data. Lane 3 is [31:24] and lane 0 is [7:0].
- `byteen`, input, 4: lane enables. 4'b0000 with `wr_en` is a no-op.
- `flush`, input, 1: synchronous discard of all queued bytes.
- `clr_ovf`, input, 1: clears the sticky `overflow` flag.
- `tx_avai`, input, 1: the transmitter is idle and will capture `tx_data` this cycle if `tx_start` is high.
- `tx_start`, output, 1: a byte is offered to the transmitter.
- `tx_data`, output, 8: the byte at the FIFO head.
- `level`, output, AW+1: number of queued bytes, 0..DEPTH.
- `empty`, output, 1: `level` == 0.
- `full`, output, 1: `level` == DEPTH.
- `overflow`, output, 1: sticky flag; a store was rejected.

## Operation
- **Storage:** `mem[DEPTH]` of 8 bits, plus `wr_ptr`, `rd_ptr` (AW bits, wrapping modulo DEPTH) and `level` (AW+1 bits).
- **Push count:** n = popcount(`byteen`), 0..4.
- **Push ordering:** enabled lanes are written in order lane 3, 2, 1, 0, skipping disabled lanes. They go to consecutive slots starting at `wr_ptr`, each slot index modulo DEPTH. Then `wr_ptr` += n.
  - Example: `byteen` = 4'b1010 writes [31:24] then [15:8].
- **Admission is all-or-nothing:**
  - If `wr_en` is high and n > DEPTH − `level` (pre-pop value this cycle), no byte is written, pointers are unchanged and `overflow` is set to 1.
  - A pop in the same cycle does not create room for that store.
- **Pop:**
  - `tx_start` = !`empty` & !`flush`. It is combinational from registered state and `flush`.
  - A pop happens on every cycle where `tx_start` & `tx_avai`: `rd_ptr` += 1.
  - The transmitter drops `tx_avai` the cycle after capture, so one offer yields exactly one pop.
- **`tx_data`** = `mem[rd_ptr]` when !`empty`, otherwise 8'h00.
- **`level` update:** next `level` = `level` + (admitted ? n : 0) − (pop ? 1 : 0). It never exceeds DEPTH and never underflows.
- **`flush`:**
  - Sets `wr_ptr` = `rd_ptr` = `level` = 0 and gates `tx_start` low that cycle, so no pop occurs.
  - Any concurrent store is discarded and does not set `overflow`.
  - `flush` has priority over push and pop.
- **`overflow`:**
  - Set by a rejected store, cleared by `clr_ovf`.
  - If both happen in the same cycle, the set wins.
  - `flush` does not clear it.

## Timing
- **Reset values:** while `reset` is asserted, without waiting for a clock edge: `wr_ptr` = `rd_ptr` = 0, `level` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `tx_start` = 0, `tx_data` = 8'h00. `mem` contents are don't-care.
- **Reset mid-transmission:** all queued bytes are lost. A byte already captured by the transmitter completes on its own.
- **Write-to-offer latency:** a byte pushed at edge k is visible on `tx_data`, with `tx_start` high, in the cycle after edge k. It can be popped at edge k+1 if `tx_avai` is high.
- **Back-to-back pops:** at most one pop per cycle, and only when `tx_avai` is high. Throughput is therefore bounded by the transmitter frame time.
- **Flag update:** `level`, `empty`, `full` and `overflow` are registered-derived and update on the edge after the causing event.
- **Wrap-around:** a 4-byte push that straddles slot DEPTH−1 continues at slot 0. Ordering is preserved.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → all outputs immediately show the reset values (`tx_start` = 0, `level` = 0, `empty` = 1, `overflow` = 0).
- **Word store:** store 32'h4142_4344 with `byteen` = 4'b1111 and the `tx_avai` model idle → `level` becomes 4, and the transmitter receives 8'h41, 8'h42, 8'h43, 8'h44 in that order. Exactly 4 pops occur and `empty` = 1 afterwards.
- **Sparse lanes:** store 32'h0055_0066 with `byteen` = 4'b0101 → two bytes are queued, transmitted as 8'h55 then 8'h66.
- **Overflow:** with DEPTH = 16 and `tx_avai` held low, perform 4 word stores (`level` = 16, `full` = 1), then 1 byte store → the byte is rejected, `level` stays 16 and `overflow` = 1. Then pulse `clr_ovf` → `overflow` = 0.
- **Boundary store and same-cycle pop:**
  - At `level` = 13, a 4-byte store concurrent with a pop → the store is rejected, `level` = 12, `overflow` = 1.
  - At `level` = 12, the same concurrent store and pop → the store is accepted, `level` = 15.
  - Check wrap-around ordering with `wr_ptr` = 14 before the push.
- **Flush:** queue 6 bytes, then assert `flush` together with `tx_avai` = 1 and a new store → `tx_start` = 0 that cycle, no pop, `level` = 0 next cycle, `overflow` unchanged.
